// File: rtl/wb_trace_serializer.sv
// Dual-writeback trace FIFO: qualifies up to two register-file writes per cycle,
// queues them in channel order, and counts retired instructions.
module wb_trace_serializer #(
  parameter int DEPTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     resetn,
  input  logic                     wb0_en,
  input  logic [4:0]               wb0_rd,
  input  logic [31:0]              wb0_wdata,
  input  logic [31:0]              wb0_pc,
  input  logic                     wb1_en,
  input  logic [4:0]               wb1_rd,
  input  logic [31:0]              wb1_wdata,
  input  logic [31:0]              wb1_pc,
  input  logic [1:0]               retire_cnt,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [31:0]              inst_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [4:0]    r_rd_mem    [DEPTH];
  logic [31:0]   r_wdata_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic [31:0]   r_inst_cnt;

  logic          w_q0;
  logic          w_q1;
  logic [1:0]    w_num_q;
  logic [LW-1:0] w_free;
  logic          w_drop;
  logic [1:0]    w_push_cnt;
  logic          w_pop;
  logic [31:0]   w_s0_pc;
  logic [4:0]    w_s0_rd;
  logic [31:0]   w_s0_wdata;
  logic [1:0]    w_add;
  logic [32:0]   w_sum;

  always_comb begin
    w_q0       = wb0_en && (wb0_rd != 5'd0);
    w_q1       = wb1_en && (wb1_rd != 5'd0);
    w_num_q    = {1'b0, w_q0} + {1'b0, w_q1};
    // Room is judged on the start-of-cycle level; a pop this cycle does not help.
    w_free     = LW'(DEPTH) - r_level;
    w_drop     = LW'(w_num_q) > w_free;
    w_push_cnt = w_drop ? w_free[1:0] : w_num_q;
    w_pop      = (r_level != '0) && out_ready;
    // First write slot takes channel 0 when it qualifies, else channel 1.
    w_s0_pc    = w_q0 ? wb0_pc    : wb1_pc;
    w_s0_rd    = w_q0 ? wb0_rd    : wb1_rd;
    w_s0_wdata = w_q0 ? wb0_wdata : wb1_wdata;
    w_add      = (retire_cnt == 2'd3) ? 2'd2 : retire_cnt;
    w_sum      = {1'b0, r_inst_cnt} + 33'(w_add);
  end

  // Storage carries no reset; validity is tracked by the level counter alone.
  always_ff @(posedge sys_clk) begin
    if (w_push_cnt != 2'd0) begin
      r_pc_mem[r_wr_ptr]    <= w_s0_pc;
      r_rd_mem[r_wr_ptr]    <= w_s0_rd;
      r_wdata_mem[r_wr_ptr] <= w_s0_wdata;
    end
    if (w_push_cnt == 2'd2) begin
      r_pc_mem[r_wr_ptr + PW'(1)]    <= wb1_pc;
      r_rd_mem[r_wr_ptr + PW'(1)]    <= wb1_rd;
      r_wdata_mem[r_wr_ptr + PW'(1)] <= wb1_wdata;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_inst_cnt <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PW'(w_push_cnt);
      r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
      r_level    <= r_level + LW'(w_push_cnt) - LW'(w_pop);
      r_overflow <= r_overflow | w_drop;
      r_inst_cnt <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    end
  end

  assign out_valid = (r_level != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : 32'd0;
  assign out_rd    = out_valid ? r_rd_mem[r_rd_ptr]    : 5'd0;
  assign out_wdata = out_valid ? r_wdata_mem[r_rd_ptr] : 32'd0;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign inst_cnt  = r_inst_cnt;

endmodule
